// File: rtl/ram_frame_reader_pkg.sv
// Shared types and constants for the frame reader and the measurement stage
// that consumes its sample stream.
package ram_frame_reader_pkg;

    localparam int DATA_W      = 8;
    localparam int SAMPLE_W    = DATA_W;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_GAP_CYC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } frame_state_e;

    // Width of a counter that must hold 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_frame_reader_rd_valid_pipe.sv
// RD_LAT-deep shift register that carries the read-enable bit in step with
// the RAM read latency, so the valid bit lines up with ram_q.
module rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rden,
    output logic vld
);

    logic [RD_LAT-1:0] sr_q;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= rden;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= {sr_q[RD_LAT-2:0], rden};
                end
            end
        end
    endgenerate

    assign vld = sr_q[RD_LAT-1];

endmodule

// File: rtl/ram_frame_reader.sv
// Reads one frame from the sample RAM after each capture (or continuously
// in auto_run) and re-times it as an enable-qualified sample stream.
module ram_frame_reader
    import ram_frame_reader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic              clk_frame,
    input  logic              rst_frame,
    input  logic              capture_done,
    input  logic              auto_run,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_rdaddr,
    output logic              ram_rden,
    output logic [DATA_W-1:0] ram_data,
    output logic              data_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int FW = cnt_w(RD_LAT);
    localparam int GW = cnt_w(GAP_CYC);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [FW-1:0]     FLUSH_LAST = FW'(RD_LAT - 1);
    localparam logic [GW-1:0]     GAP_LAST   = GW'(GAP_CYC - 1);

    frame_state_e  state_q, state_d;
    logic          pending_q;
    logic          start_frame;
    logic          want_frame;
    logic          gap_last;
    logic          rd_vld;
    logic [FW-1:0] flush_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    assign want_frame = capture_done | pending_q | auto_run;
    assign gap_last   = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = gap_last;

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (want_frame) begin
                    state_d     = ST_READ;
                    start_frame = 1'b1;
                end
            end
            ST_READ: begin
                if (ram_rdaddr == LAST_ADDR) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) begin
                    if (want_frame) begin
                        state_d     = ST_READ;
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address is cleared whenever READ is entered or left, so it never wraps
    // past LAST_ADDR even when DEPTH fills the whole address space.
    always_ff @(posedge clk_frame or posedge rst_frame) begin
        if (rst_frame) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            flush_cnt_q <= '0;
            gap_cnt_q   <= '0;
            ram_rdaddr  <= '0;
            ram_rden    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_rden    <= (state_d == ST_READ);
            ram_rdaddr  <= (state_q == ST_READ && state_d == ST_READ) ?
                           ram_rdaddr + 1'b1 : '0;
            flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + 1'b1 : '0;
            gap_cnt_q   <= (state_q == ST_GAP) ? gap_cnt_q + 1'b1 : '0;
            if (start_frame) begin
                pending_q <= 1'b0;
            end else if (capture_done && busy) begin
                pending_q <= 1'b1;
            end
        end
    end

    rd_valid_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_valid_pipe (
        .clk  (clk_frame),
        .rst  (rst_frame),
        .rden (ram_rden),
        .vld  (rd_vld)
    );

    // data_en is a plain valid for ram_data: the consumer has no ready, it
    // takes every sample on each cycle data_en is high.
    always_ff @(posedge clk_frame or posedge rst_frame) begin
        if (rst_frame) begin
            data_en  <= 1'b0;
            ram_data <= '0;
        end else begin
            data_en  <= rd_vld;
            ram_data <= rd_vld ? ram_q : '0;
        end
    end

endmodule

// File: tb/tb_ram_frame_reader.sv
// Bench for ram_frame_reader: instance A (256/1/4) and instance B (16/2/2)
// against a frame-timeline model, plus directed literal checks.
module tb_ram_frame_reader;
    import ram_frame_reader_pkg::*;

    localparam int N = 2;

    function automatic int dep(input int i); return (i == 0) ? 256 : 16; endfunction
    function automatic int lat(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int gap(input int i); return (i == 0) ? 4 : 2; endfunction
    function automatic int per(input int i); return dep(i) + lat(i) + gap(i); endfunction
    function automatic string nm(input int i); return (i == 0) ? "A" : "B"; endfunction

    logic       clk;
    logic       rst;
    logic       cap    [N];
    logic       auto_r [N];
    logic [7:0] o_addr [N];
    logic       o_rden [N];
    logic [7:0] o_data [N];
    logic       o_en   [N];
    logic       o_busy [N];
    logic       o_fd   [N];
    logic [7:0] mem    [N][256];
    logic [7:0] q1     [N];
    logic [7:0] q2     [N];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // frame-timeline model: t counts cycles since the first READ cycle
    bit m_act  [N];
    int m_t    [N];
    bit m_pend [N];

    // stream statistics gathered at the sampling edge
    bit p_rd [N];
    bit p_en [N];
    int rden_rise [N];
    int rise_after_fd [N];
    int rd_run [N];
    int last_rd_run [N];
    int en_rise [N];
    int en_rise_prev [N];
    int en_run [N];
    int last_en_run [N];
    int first_data [N];
    int cur_last [N];
    int last_data [N];
    int mx [N];
    int mn [N];
    int meas_max [N];
    int meas_min [N];
    int fd_cnt [N];
    int last_fd [N];
    int max_addr [N];

    ram_frame_reader #(.ADDR_W(8), .DEPTH(256), .RD_LAT(1), .GAP_CYC(4)) u_a (
        .clk_frame(clk), .rst_frame(rst), .capture_done(cap[0]), .auto_run(auto_r[0]),
        .ram_q(q1[0]), .ram_rdaddr(o_addr[0]), .ram_rden(o_rden[0]), .ram_data(o_data[0]),
        .data_en(o_en[0]), .busy(o_busy[0]), .frame_done(o_fd[0])
    );

    ram_frame_reader #(.ADDR_W(8), .DEPTH(16), .RD_LAT(2), .GAP_CYC(2)) u_b (
        .clk_frame(clk), .rst_frame(rst), .capture_done(cap[1]), .auto_run(auto_r[1]),
        .ram_q(q2[1]), .ram_rdaddr(o_addr[1]), .ram_rden(o_rden[1]), .ram_data(o_data[1]),
        .data_en(o_en[1]), .busy(o_busy[1]), .frame_done(o_fd[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sample RAMs: registered read, optional second output register
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (o_rden[i]) q1[i] <= mem[i][o_addr[i]];
            q2[i] <= q1[i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_act[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_pend[i] <= 1'b0;
            end else if (!m_act[i] || m_t[i] == per(i) - 1) begin
                if (cap[i] || m_pend[i] || auto_r[i]) begin
                    m_act[i]  <= 1'b1;
                    m_t[i]    <= 0;
                    m_pend[i] <= 1'b0;
                end else begin
                    m_act[i] <= 1'b0;
                end
            end else begin
                m_t[i] <= m_t[i] + 1;
                if (cap[i]) m_pend[i] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
    endtask

    // scoreboard: compare every cycle against the model, collect statistics
    always @(negedge clk) begin
        bit e_busy, e_rd, e_en, e_fd;
        logic [7:0] e_addr, e_data;
        int t;
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                t      = m_t[i];
                e_busy = !rst && m_act[i];
                e_rd   = e_busy && t < dep(i);
                e_addr = e_rd ? 8'(t) : 8'd0;
                e_en   = e_busy && t >= lat(i) + 1 && t < lat(i) + 1 + dep(i);
                e_data = e_en ? mem[i][t - lat(i) - 1] : 8'd0;
                e_fd   = e_busy && t == per(i) - 1;
                check({nm(i), ".busy"}, 32'(o_busy[i]), 32'(e_busy));
                check({nm(i), ".rden"}, 32'(o_rden[i]), 32'(e_rd));
                check({nm(i), ".addr"}, 32'(o_addr[i]), 32'(e_addr));
                check({nm(i), ".data_en"}, 32'(o_en[i]), 32'(e_en));
                check({nm(i), ".data"}, 32'(o_data[i]), 32'(e_data));
                check({nm(i), ".frame_done"}, 32'(o_fd[i]), 32'(e_fd));

                if (o_rden[i] && !p_rd[i]) begin
                    rden_rise[i]     = cyc;
                    rise_after_fd[i] = cyc - last_fd[i];
                end
                if (o_rden[i]) rd_run[i]++;
                else if (p_rd[i]) begin
                    last_rd_run[i] = rd_run[i];
                    rd_run[i]      = 0;
                end
                if (o_en[i] && !p_en[i]) begin
                    en_rise_prev[i] = en_rise[i];
                    en_rise[i]      = cyc;
                    first_data[i]   = o_data[i];
                    mx[i]           = o_data[i];
                    mn[i]           = o_data[i];
                    en_run[i]       = 0;
                end
                if (o_en[i]) begin
                    en_run[i]++;
                    cur_last[i] = o_data[i];
                    if (o_data[i] > mx[i]) mx[i] = o_data[i];
                    if (o_data[i] < mn[i]) mn[i] = o_data[i];
                end else if (p_en[i]) begin
                    last_en_run[i] = en_run[i];
                    last_data[i]   = cur_last[i];
                    meas_max[i]    = mx[i];
                    meas_min[i]    = mn[i];
                end
                if (o_fd[i]) begin
                    fd_cnt[i]++;
                    last_fd[i] = cyc;
                end
                if (o_addr[i] > max_addr[i]) max_addr[i] = o_addr[i];
                p_rd[i] = o_rden[i];
                p_en[i] = o_en[i];
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i);
        cap[i] = 1'b1;
        tick();
        cap[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (o_busy[i] && n < budget) begin tick(); n++; end
        if (o_busy[i]) timeout({nm(i), ".wait_idle"});
    endtask

    task automatic wait_fd_pulse(input int i, input int budget);
        int n = 0;
        while (!o_fd[i] && n < budget) begin tick(); n++; end
        if (!o_fd[i]) timeout({nm(i), ".wait_frame_done"});
    endtask

    task automatic wait_fd_count(input int i, input int target, input int budget);
        int n = 0;
        while (fd_cnt[i] < target && n < budget) begin tick(); n++; end
        if (fd_cnt[i] < target) timeout({nm(i), ".wait_fd_count"});
    endtask

    task automatic wait_addr(input int i, input int a, input int budget);
        int n = 0;
        while (!(o_rden[i] && o_addr[i] == 8'(a)) && n < budget) begin tick(); n++; end
        if (!(o_rden[i] && o_addr[i] == 8'(a))) timeout({nm(i), ".wait_addr"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cap[i]    = 1'b0;
            auto_r[i] = 1'b0;
        end
        for (int j = 0; j < 256; j++) begin
            mem[0][j] = 8'(j);
            mem[1][j] = 8'(8'hA0 + j);
        end
        repeat (3) tick();
        check("A.reset_busy", 32'(o_busy[0]), 0);
        check("A.reset_data_en", 32'(o_en[0]), 0);
        rst = 1'b0;
        tick();

        // single frame, ramp contents
        fd0 = fd_cnt[0];
        pulse(0);
        wait_idle(0, 400);
        check("t1.rden_len", 32'(last_rd_run[0]), 256);
        check("t1.en_len", 32'(last_en_run[0]), 256);
        check("t1.en_latency", 32'(en_rise[0] - rden_rise[0]), 2);
        check("t1.first_data", 32'(first_data[0]), 0);
        check("t1.last_data", 32'(last_data[0]), 255);
        check("t1.frame_done_cnt", 32'(fd_cnt[0] - fd0), 1);
        check("t1.busy_after", 32'(o_busy[0]), 0);

        // downstream max/min over values 20..200
        for (int j = 0; j < 256; j++) mem[0][j] = 8'(20 + (j % 181));
        pulse(0);
        wait_idle(0, 400);
        check("t2.max", 32'(meas_max[0]), 200);
        check("t2.min", 32'(meas_min[0]), 20);
        check("t2.p2p", 32'(meas_max[0] - meas_min[0]), 180);
        for (int j = 0; j < 256; j++) mem[0][j] = 8'(255 - j);

        // three captures during READ collapse into one extra frame
        fd0 = fd_cnt[0];
        pulse(0);
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            pulse(0);
            repeat (5) tick();
        end
        wait_idle(0, 800);
        check("t3.frame_done_cnt", 32'(fd_cnt[0] - fd0), 2);
        check("t3.restart_gap", 32'(rise_after_fd[0]), 1);

        // auto_run on B, started together with a capture pulse
        fd0 = fd_cnt[1];
        auto_r[1] = 1'b1;
        cap[1]    = 1'b1;
        tick();
        cap[1] = 1'b0;
        wait_fd_count(1, fd0 + 2, 100);
        tick();
        auto_r[1] = 1'b0;
        wait_idle(1, 100);
        check("t4.frame_done_cnt", 32'(fd_cnt[1] - fd0), 3);
        check("t4.en_len", 32'(last_en_run[1]), 16);
        check("t4.rden_len", 32'(last_rd_run[1]), 16);
        check("t4.period", 32'(en_rise[1] - en_rise_prev[1]), 20);
        check("t4.max_addr", 32'(max_addr[1]), 15);

        // reset in the middle of a frame
        pulse(0);
        wait_addr(0, 100, 200);
        rst = 1'b1;
        #1;
        check("t5.addr", 32'(o_addr[0]), 0);
        check("t5.rden", 32'(o_rden[0]), 0);
        check("t5.data", 32'(o_data[0]), 0);
        check("t5.data_en", 32'(o_en[0]), 0);
        check("t5.busy", 32'(o_busy[0]), 0);
        check("t5.frame_done", 32'(o_fd[0]), 0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("t5.idle_busy", 32'(o_busy[0]), 0);
        check("t5.idle_rden", 32'(o_rden[0]), 0);

        // capture coincident with the final GAP cycle
        fd0 = fd_cnt[0];
        pulse(0);
        wait_fd_pulse(0, 400);
        cap[0] = 1'b1;
        tick();
        cap[0] = 1'b0;
        check("t6.rden", 32'(o_rden[0]), 1);
        check("t6.addr", 32'(o_addr[0]), 0);
        check("t6.busy", 32'(o_busy[0]), 1);
        wait_idle(0, 400);
        check("t6.frame_done_cnt", 32'(fd_cnt[0] - fd0), 2);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
